// File: rtl/p_pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: op codes, fault bit
// indices and width helpers for the return-address stack.
package p_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  localparam int unsigned FLT_OVF  = 0;
  localparam int unsigned FLT_UNF  = 1;
  localparam int unsigned FLT_ALN  = 2;
  localparam int unsigned FLT_BITS = 3;

  // Bits needed to hold an entry count of 0..depth.
  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (at least one bit).
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/c_return_stack.sv
// Circular return-address stack. When full, a push either overwrites the
// oldest entry (WRAP=1) or is dropped (WRAP=0); ovf/unf flag the attempt.
module c_return_stack
  import p_pc_sequencer_pkg::*;
#(
  parameter int unsigned BITS  = 16,
  parameter int unsigned DEPTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [BITS-1:0]            din,
  output logic [BITS-1:0]            top,
  output logic [cnt_bits(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned CW = cnt_bits(DEPTH);
  localparam int unsigned PW = ptr_bits(DEPTH);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]   count_q, count_d;

  // Modulo-DEPTH pointer steps; explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign ovf   = push & full;
  assign unf   = pop & empty;
  assign top   = empty ? '0 : mem_q[ptr_dec];
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push && (!full || WRAP)) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_inc;
      if (!full) begin
        count_d = count_q + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr_d   = ptr_dec;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; empty masks stale contents on top.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/p_pc_sequencer.sv
// Program-counter sequencer: fetch-address register, next-PC selection for
// SEQ/JUMP/CALL/RET, target alignment and sticky fault reporting.
module p_pc_sequencer
  import p_pc_sequencer_pkg::*;
#(
  parameter int unsigned          ADDR_BITS  = 16,
  parameter int unsigned          INST_BYTES = 2,
  parameter int unsigned          RAS_DEPTH  = 4,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0,
  parameter bit                   OVF_WRAP   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [1:0]                     op,
  input  logic [ADDR_BITS-1:0]           target,
  input  logic                           fault_clr,
  output logic [ADDR_BITS-1:0]           pc,
  output logic [ADDR_BITS-1:0]           ra,
  output logic [cnt_bits(RAS_DEPTH)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic [FLT_BITS-1:0]            fault
);

  localparam logic [ADDR_BITS-1:0] ALN_MASK = ADDR_BITS'(INST_BYTES - 1);

  op_e                  op_c;
  logic [ADDR_BITS-1:0] pc_q, pc_d, nxt, tgt, stk_top;
  logic [FLT_BITS-1:0]  fault_q, fault_d, ev;
  logic                 mis, push, pop;
  logic                 stk_full, stk_empty, stk_ovf, stk_unf;

  assign op_c = op_e'(op);

  c_return_stack #(
    .BITS  (ADDR_BITS),
    .DEPTH (RAS_DEPTH),
    .WRAP  (OVF_WRAP)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (nxt),
    .top   (stk_top),
    .count (ras_count),
    .full  (stk_full),
    .empty (stk_empty),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

  always_comb begin
    nxt  = pc_q + ADDR_BITS'(INST_BYTES);
    tgt  = target & ~ALN_MASK;
    mis  = |(target & ALN_MASK);
    push = !stall && (op_c == OP_CALL);
    pop  = !stall && (op_c == OP_RET);
    pc_d = pc_q;
    ev   = '0;
    if (!stall) begin
      case (op_c)
        OP_SEQ:  pc_d = nxt;
        OP_JUMP: begin
          pc_d         = tgt;
          ev[FLT_ALN]  = mis;
        end
        OP_CALL: begin
          // A rejected call (full, no wrap) falls through to the next instruction.
          pc_d         = (stk_full && !OVF_WRAP) ? nxt : tgt;
          ev[FLT_OVF]  = stk_ovf;
          ev[FLT_ALN]  = mis;
        end
        OP_RET: begin
          pc_d         = stk_empty ? tgt : stk_top;
          ev[FLT_UNF]  = stk_unf;
        end
      endcase
    end
    // A clear still lets this cycle's new events through.
    fault_d = (fault_clr ? '0 : fault_q) | ev;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      fault_q <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc        = pc_q;
  assign fault     = fault_q;
  assign ra        = stk_top;
  assign ras_full  = stk_full;
  assign ras_empty = stk_empty;

endmodule

// File: tb/tb_p_pc_sequencer.sv
// Bench for p_pc_sequencer: directed vector table plus random traffic on three
// configurations, checked against a list-based return-stack model.
module tb_p_pc_sequencer;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  op;
    logic [15:0] target;
    logic        clr;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic [15:0] e_ra;
    logic [2:0]  e_flt;
  } vec_t;

  localparam int NI = 3;
  localparam int DEP [NI] = '{4, 4, 3};
  localparam int WR  [NI] = '{1, 0, 1};

  logic        clk, rst, stall, fault_clr;
  logic [1:0]  op;
  logic [15:0] target;

  logic [15:0] pc0, pc1, pc2, ra0, ra1, ra2;
  logic [2:0]  cnt0, cnt1, flt0, flt1, flt2;
  logic [1:0]  cnt2;
  logic        full0, full1, full2, empty0, empty1, empty2;

  logic [15:0] a_pc  [NI];
  logic [15:0] a_ra  [NI];
  logic [2:0]  a_cnt [NI];
  logic [2:0]  a_flt [NI];
  logic        a_full  [NI];
  logic        a_empty [NI];

  logic [15:0] m_pc  [NI];
  logic [15:0] m_stk [NI][4];
  int          m_cnt [NI];
  logic [2:0]  m_flt [NI];

  int   checks, errors;
  vec_t vq[$];

  p_pc_sequencer u0 (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .fault_clr(fault_clr),
    .pc(pc0), .ra(ra0), .ras_count(cnt0), .ras_full(full0), .ras_empty(empty0), .fault(flt0));

  p_pc_sequencer #(.OVF_WRAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .fault_clr(fault_clr),
    .pc(pc1), .ra(ra1), .ras_count(cnt1), .ras_full(full1), .ras_empty(empty1), .fault(flt1));

  p_pc_sequencer #(.RAS_DEPTH(3)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .fault_clr(fault_clr),
    .pc(pc2), .ra(ra2), .ras_count(cnt2), .ras_full(full2), .ras_empty(empty2), .fault(flt2));

  assign a_pc[0] = pc0;  assign a_pc[1] = pc1;  assign a_pc[2] = pc2;
  assign a_ra[0] = ra0;  assign a_ra[1] = ra1;  assign a_ra[2] = ra2;
  assign a_cnt[0] = cnt0; assign a_cnt[1] = cnt1; assign a_cnt[2] = {1'b0, cnt2};
  assign a_flt[0] = flt0; assign a_flt[1] = flt1; assign a_flt[2] = flt2;
  assign a_full[0] = full0; assign a_full[1] = full1; assign a_full[2] = full2;
  assign a_empty[0] = empty0; assign a_empty[1] = empty1; assign a_empty[2] = empty2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: stack held as an ordered list, oldest at index 0.
  task automatic model_step();
    logic [15:0] nxt, tgt;
    logic [2:0]  ev;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_pc[i]  = 16'h0000;
        m_cnt[i] = 0;
        m_flt[i] = 3'b000;
      end else begin
        nxt = m_pc[i] + 16'd2;
        tgt = {target[15:1], 1'b0};
        ev  = 3'b000;
        if (!stall) begin
          case (op)
            2'd0: m_pc[i] = nxt;
            2'd1: begin m_pc[i] = tgt; ev[2] = target[0]; end
            2'd2: begin
              ev[2] = target[0];
              if (m_cnt[i] < DEP[i]) begin
                m_stk[i][m_cnt[i]] = nxt;
                m_cnt[i]++;
                m_pc[i] = tgt;
              end else begin
                ev[0] = 1'b1;
                if (WR[i] != 0) begin
                  for (int j = 0; j < DEP[i] - 1; j++) m_stk[i][j] = m_stk[i][j+1];
                  m_stk[i][DEP[i]-1] = nxt;
                  m_pc[i] = tgt;
                end else begin
                  m_pc[i] = nxt;
                end
              end
            end
            default: begin
              if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                m_pc[i] = m_stk[i][m_cnt[i]];
              end else begin
                m_pc[i] = tgt;
                ev[1] = 1'b1;
              end
            end
          endcase
        end
        m_flt[i] = (fault_clr ? 3'b000 : m_flt[i]) | ev;
      end
    end
  endtask

  task automatic cmp_model();
    logic [15:0] mra;
    for (int i = 0; i < NI; i++) begin
      mra = (m_cnt[i] > 0) ? m_stk[i][m_cnt[i]-1] : 16'h0000;
      chk($sformatf("u%0d_pc", i), 32'(a_pc[i]), 32'(m_pc[i]));
      chk($sformatf("u%0d_ra", i), 32'(a_ra[i]), 32'(mra));
      chk($sformatf("u%0d_cnt", i), 32'(a_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("u%0d_full", i), 32'(a_full[i]), 32'(m_cnt[i] == DEP[i]));
      chk($sformatf("u%0d_empty", i), 32'(a_empty[i]), 32'(m_cnt[i] == 0));
      chk($sformatf("u%0d_fault", i), 32'(a_flt[i]), 32'(m_flt[i]));
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [1:0] o,
                      input logic [15:0] t, input logic c);
    rst = r; stall = s; op = o; target = t; fault_clr = c;
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; stall = 1'b0; op = 2'd0; target = 16'h0; fault_clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_pc[i] = 16'h0; m_cnt[i] = 0; m_flt[i] = 3'b0;
      for (int j = 0; j < 4; j++) m_stk[i][j] = 16'h0;
    end

    //           rst  stl  op     target    clr   pc        cnt   ra        flt   (expected for u0)
    vq.push_back('{1'b0,1'b0,2'd0,16'h0000,1'b0,16'h0000,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b0,16'h0002,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b0,16'h0004,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b0,16'h0006,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd1,16'hFFFE,1'b0,16'hFFFE,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b0,16'h0000,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd1,16'h0010,1'b0,16'h0010,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h0100,1'b0,16'h0100,3'd1,16'h0012,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h0200,1'b0,16'h0200,3'd2,16'h0102,3'b000});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h0102,3'd1,16'h0012,3'b000});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h0012,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h1000,1'b0,16'h1000,3'd1,16'h0014,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h2000,1'b0,16'h2000,3'd2,16'h1002,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h3000,1'b0,16'h3000,3'd3,16'h2002,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h4000,1'b0,16'h4000,3'd4,16'h3002,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h5000,1'b0,16'h5000,3'd4,16'h4002,3'b001});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h4002,3'd3,16'h3002,3'b001});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h3002,3'd2,16'h2002,3'b001});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h2002,3'd1,16'h1002,3'b001});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0000,1'b0,16'h1002,3'd0,16'h0000,3'b001});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0ABD,1'b0,16'h0ABC,3'd0,16'h0000,3'b011});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b1,16'h0ABE,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd1,16'h0033,1'b0,16'h0032,3'd0,16'h0000,3'b100});
    vq.push_back('{1'b1,1'b0,2'd0,16'h0000,1'b1,16'h0034,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b1,2'd2,16'h0100,1'b0,16'h0034,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd1,16'h0041,1'b0,16'h0040,3'd0,16'h0000,3'b100});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0050,1'b1,16'h0050,3'd0,16'h0000,3'b010});
    vq.push_back('{1'b1,1'b1,2'd1,16'h0101,1'b1,16'h0050,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h0200,1'b0,16'h0200,3'd1,16'h0052,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h0300,1'b0,16'h0300,3'd2,16'h0202,3'b000});
    vq.push_back('{1'b1,1'b0,2'd2,16'h0401,1'b0,16'h0400,3'd3,16'h0302,3'b100});
    vq.push_back('{1'b0,1'b1,2'd2,16'h0500,1'b1,16'h0000,3'd0,16'h0000,3'b000});
    vq.push_back('{1'b1,1'b0,2'd3,16'h0010,1'b0,16'h0010,3'd0,16'h0000,3'b010});

    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].rst, vq[k].stall, vq[k].op, vq[k].target, vq[k].clr);
      chk($sformatf("vec%0d_pc", k), 32'(pc0), 32'(vq[k].e_pc));
      chk($sformatf("vec%0d_cnt", k), 32'(cnt0), 32'(vq[k].e_cnt));
      chk($sformatf("vec%0d_ra", k), 32'(ra0), 32'(vq[k].e_ra));
      chk($sformatf("vec%0d_fault", k), 32'(flt0), 32'(vq[k].e_flt));
      if (k == 15) begin
        // Non-wrapping build suppresses the fifth call and falls through.
        chk("nowrap_call_pc", 32'(pc1), 32'h4002);
        chk("nowrap_call_cnt", 32'(cnt1), 32'd4);
        chk("nowrap_call_ra", 32'(ra1), 32'h3002);
        chk("nowrap_call_fault", 32'(flt1), 32'b001);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) != 0), ($urandom_range(7) == 0),
           2'($urandom_range(3)), 16'($urandom), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
